// File: rtl/i2c_target_core.sv
// -----------------------------------------------------------------------------
// i2c_target_core
//
// I2C target (slave) protocol engine for one 7-bit address. SDA/SCL are
// sampled through 2-FF synchronizers plus a history stage. START/STOP and SCL
// edges are detected in the clk domain from those samples. The core ACKs
// address and write bytes, returns bytes on reads, and stretches SCL while no
// transmit byte is ready.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   sda_i      in   SDA line level (asynchronous)
//   scl_i      in   SCL line level (asynchronous)
//   sda_o      out  SDA drive, 0 = pull low, 1 = release
//   scl_o      out  SCL drive, 0 = hold low (stretch), 1 = release
//   rxdata     out  last byte written by the controller
//   rx_valid   out  pulse, rxdata updated
//   txdata     in   next byte to return on a read
//   tx_valid   in   txdata is ready
//   tx_req     out  pulse, txdata consumed
//   addressed  out  a transfer to TARGET_ADDR is active
//   rw         out  R/W bit of the current transfer (1 = read)
//   start_det  out  pulse on START or repeated START
//   stop_det   out  pulse on STOP
//   ack_fail   out  pulse when the controller NACKs a read byte
// -----------------------------------------------------------------------------
module i2c_target_core #(
   parameter logic [6:0] TARGET_ADDR = 7'h50
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sda_i,
   input  logic       scl_i,
   output logic       sda_o,
   output logic       scl_o,
   output logic [7:0] rxdata,
   output logic       rx_valid,
   input  logic [7:0] txdata,
   input  logic       tx_valid,
   output logic       tx_req,
   output logic       addressed,
   output logic       rw,
   output logic       start_det,
   output logic       stop_det,
   output logic       ack_fail
);

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      ADDR      = 4'd1,
      ADDR_ACK  = 4'd2,
      RX        = 4'd3,
      RX_ACK    = 4'd4,
      TX_LOAD   = 4'd5,
      TX        = 4'd6,
      TX_ACK    = 4'd7,
      WAIT_STOP = 4'd8
   } state_t;

   // ---------------------------------------------------------------------------
   // Input synchronizers: [0] and [1] are the 2-FF synchronizer, [2] holds the
   // previous synchronized value for edge detection.
   // ---------------------------------------------------------------------------
   logic [2:0] sda_sync_q, sda_sync_d;
   logic [2:0] scl_sync_q, scl_sync_d;
   logic [1:0] settle_q, settle_d;

   always_comb begin
      sda_sync_d = {sda_sync_q[1:0], sda_i};
      scl_sync_d = {scl_sync_q[1:0], scl_i};
      // Counts the cycles after reset release until the history stage holds a
      // real line sample; detection is suppressed until then.
      settle_d   = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
   end

   logic sda_s, sda_h, scl_s, scl_h, det_en;
   logic scl_rise, scl_fall, start_cond, stop_cond;

   assign sda_s  = sda_sync_q[1];
   assign sda_h  = sda_sync_q[2];
   assign scl_s  = scl_sync_q[1];
   assign scl_h  = scl_sync_q[2];
   assign det_en = (settle_q == 2'd3);

   assign scl_rise   = det_en &  scl_s & ~scl_h;
   assign scl_fall   = det_en & ~scl_s &  scl_h;
   assign start_cond = det_en &  scl_s &  scl_h &  sda_h & ~sda_s;
   assign stop_cond  = det_en &  scl_s &  scl_h & ~sda_h &  sda_s;

   // ---------------------------------------------------------------------------
   // Protocol state
   // ---------------------------------------------------------------------------
   state_t     state_q,     state_d;
   logic [3:0] bit_cnt_q,   bit_cnt_d;
   logic [7:0] shift_q,     shift_d;
   logic [7:0] rxdata_q,    rxdata_d;
   logic       rw_q,        rw_d;
   logic       addressed_q, addressed_d;
   logic       sda_o_q,     sda_o_d;
   logic       rx_valid_q,  rx_valid_d;
   logic       tx_req_q,    tx_req_d;
   logic       start_det_q, start_det_d;
   logic       stop_det_q,  stop_det_d;
   logic       ack_fail_q,  ack_fail_d;

   logic [7:0] shift_in;
   logic [3:0] bit_cnt_inc;

   assign shift_in    = {shift_q[6:0], sda_s};
   assign bit_cnt_inc = bit_cnt_q + 4'd1;

   always_comb begin
      // NOTE: every signal written here gets its default first, so no path
      // through the case statement can leave one unassigned and infer a latch.
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      rxdata_d    = rxdata_q;
      rw_d        = rw_q;
      addressed_d = addressed_q;
      sda_o_d     = sda_o_q;
      rx_valid_d  = 1'b0;
      tx_req_d    = 1'b0;
      start_det_d = 1'b0;
      stop_det_d  = 1'b0;
      ack_fail_d  = 1'b0;

      if (start_cond) begin
         // START (or repeated START) abandons any partial byte.
         start_det_d = 1'b1;
         bit_cnt_d   = 4'd0;
         sda_o_d     = 1'b1;
         addressed_d = 1'b0;
         state_d     = ADDR;
      end else if (stop_cond) begin
         stop_det_d  = 1'b1;
         bit_cnt_d   = 4'd0;
         sda_o_d     = 1'b1;
         addressed_d = 1'b0;
         state_d     = IDLE;
      end else begin
         unique case (state_q)
            IDLE, WAIT_STOP: begin
               sda_o_d = 1'b1;
            end

            ADDR: begin
               if (scl_rise) begin
                  shift_d   = shift_in;
                  bit_cnt_d = bit_cnt_inc;
                  if (bit_cnt_inc == 4'd8) begin
                     bit_cnt_d = 4'd0;
                     if (shift_in[7:1] == TARGET_ADDR) begin
                        addressed_d = 1'b1;
                        rw_d        = shift_in[0];
                        state_d     = ADDR_ACK;
                     end else begin
                        state_d = WAIT_STOP;
                     end
                  end
               end
            end

            // ACK slot, sequenced by bit_cnt: 0 = wait for the falling edge
            // that ends bit 8, 1 = driving low until the 9th rising edge,
            // 2 = wait for the falling edge that ends the 9th clock.
            ADDR_ACK, RX_ACK: begin
               if (scl_fall && bit_cnt_q == 4'd0) begin
                  sda_o_d   = 1'b0;
                  bit_cnt_d = 4'd1;
               end else if (scl_rise && bit_cnt_q == 4'd1) begin
                  bit_cnt_d = 4'd2;
               end else if (scl_fall && bit_cnt_q == 4'd2) begin
                  sda_o_d   = 1'b1;
                  bit_cnt_d = 4'd0;
                  state_d   = rw_q ? TX_LOAD : RX;
               end
            end

            RX: begin
               if (scl_rise) begin
                  shift_d   = shift_in;
                  bit_cnt_d = bit_cnt_inc;
                  if (bit_cnt_inc == 4'd8) begin
                     bit_cnt_d  = 4'd0;
                     rxdata_d   = shift_in;
                     rx_valid_d = 1'b1;
                     state_d    = RX_ACK;
                  end
               end
            end

            // SCL is low here; scl_o stretches it until a byte is offered.
            TX_LOAD: begin
               if (tx_valid) begin
                  shift_d   = txdata;
                  tx_req_d  = 1'b1;
                  sda_o_d   = txdata[7];
                  bit_cnt_d = 4'd0;
                  state_d   = TX;
               end
            end

            // Bit 7 is already on the line; each falling edge presents the
            // next bit, the 8th releases SDA for the controller's ACK.
            TX: begin
               if (scl_fall) begin
                  bit_cnt_d = bit_cnt_inc;
                  if (bit_cnt_inc == 4'd8) begin
                     bit_cnt_d = 4'd0;
                     sda_o_d   = 1'b1;
                     state_d   = TX_ACK;
                  end else begin
                     shift_d = {shift_q[6:0], 1'b0};
                     sda_o_d = shift_q[6];
                  end
               end
            end

            // bit_cnt 0 = wait for the 9th rising edge, 1 = ACK seen, wait
            // for the falling edge before loading the next byte.
            TX_ACK: begin
               if (scl_rise && bit_cnt_q == 4'd0) begin
                  if (sda_s) begin
                     ack_fail_d = 1'b1;
                     state_d    = WAIT_STOP;
                  end else begin
                     bit_cnt_d = 4'd1;
                  end
               end else if (scl_fall && bit_cnt_q == 4'd1) begin
                  bit_cnt_d = 4'd0;
                  state_d   = TX_LOAD;
               end
            end

            default: begin
               sda_o_d = 1'b1;
               state_d = IDLE;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the _d values computed from the same pre-edge state.
   always_ff @(posedge clk) begin
      if (reset) begin
         // Synchronizers reset to the idle (released) line level so the first
         // real samples cannot look like a falling edge.
         sda_sync_q  <= 3'b111;
         scl_sync_q  <= 3'b111;
         settle_q    <= 2'd0;
         state_q     <= IDLE;
         bit_cnt_q   <= 4'd0;
         shift_q     <= 8'h00;
         rxdata_q    <= 8'h00;
         rw_q        <= 1'b0;
         addressed_q <= 1'b0;
         sda_o_q     <= 1'b1;
         rx_valid_q  <= 1'b0;
         tx_req_q    <= 1'b0;
         start_det_q <= 1'b0;
         stop_det_q  <= 1'b0;
         ack_fail_q  <= 1'b0;
      end else begin
         sda_sync_q  <= sda_sync_d;
         scl_sync_q  <= scl_sync_d;
         settle_q    <= settle_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         rxdata_q    <= rxdata_d;
         rw_q        <= rw_d;
         addressed_q <= addressed_d;
         sda_o_q     <= sda_o_d;
         rx_valid_q  <= rx_valid_d;
         tx_req_q    <= tx_req_d;
         start_det_q <= start_det_d;
         stop_det_q  <= stop_det_d;
         ack_fail_q  <= ack_fail_d;
      end
   end

   // Stretch is combinational on tx_valid so SCL is released in the same
   // cycle the byte becomes available.
   assign scl_o     = ~((state_q == TX_LOAD) && !tx_valid);
   assign sda_o     = sda_o_q;
   assign rxdata    = rxdata_q;
   assign rx_valid  = rx_valid_q;
   assign tx_req    = tx_req_q;
   assign addressed = addressed_q;
   assign rw        = rw_q;
   assign start_det = start_det_q;
   assign stop_det  = stop_det_q;
   assign ack_fail  = ack_fail_q;

endmodule

// File: tb/tb_i2c_target_core.sv
// -----------------------------------------------------------------------------
// tb_i2c_target_core
//
// Directed bench for i2c_target_core: a bit-level I2C controller model drives
// open-drain SDA/SCL (wired-AND with the DUT drives, honouring clock
// stretching). Written bytes and returned bytes are tracked on scoreboard
// queues; pulse outputs are counted by a monitor on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_i2c_target_core;

   localparam int Q        = 10;    // clk cycles per quarter SCL period
   localparam int SCL_WAIT = 2000;  // bound on waiting for a stretched SCL

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sda_m = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_line, scl_line;
   logic       sda_o, scl_o;
   logic [7:0] rxdata;
   logic       rx_valid;
   logic [7:0] txdata = 8'h96;
   logic       tx_valid = 1'b1;
   logic       tx_req, addressed, rw, start_det, stop_det, ack_fail;

   assign sda_line = sda_m & sda_o;
   assign scl_line = scl_m & scl_o;

   i2c_target_core #(.TARGET_ADDR(7'h50)) dut (
      .clk       (clk),
      .reset     (reset),
      .sda_i     (sda_line),
      .scl_i     (scl_line),
      .sda_o     (sda_o),
      .scl_o     (scl_o),
      .rxdata    (rxdata),
      .rx_valid  (rx_valid),
      .txdata    (txdata),
      .tx_valid  (tx_valid),
      .tx_req    (tx_req),
      .addressed (addressed),
      .rw        (rw),
      .start_det (start_det),
      .stop_det  (stop_det),
      .ack_fail  (ack_fail)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int n_rx = 0, n_txr = 0, n_start = 0, n_stop = 0, n_af = 0;
   bit sda_low_seen = 1'b0;
   logic [7:0] exp_rx[$];
   logic [7:0] exp_tx[$];

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor: counts pulses and scores write bytes against the queue.
   always @(negedge clk) begin
      if (!reset) begin
         if (rx_valid === 1'b1) begin
            n_rx++;
            check("rx_expected", exp_rx.size() != 0, 1'b1);
            if (exp_rx.size() != 0) check("rxdata", rxdata, exp_rx.pop_front());
         end
         if (tx_req === 1'b1)    n_txr++;
         if (start_det === 1'b1) n_start++;
         if (stop_det === 1'b1)  n_stop++;
         if (ack_fail === 1'b1)  n_af++;
         if (sda_o === 1'b0)     sda_low_seen = 1'b1;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "watchdog");
   end

   // --------------------------- controller model -----------------------------
   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic scl_release();
      int k = 0;
      scl_m = 1'b1;
      while (scl_line !== 1'b1 && k < SCL_WAIT) begin
         @(negedge clk);
         k++;
      end
      if (k >= SCL_WAIT) check("scl_stretch_timeout", scl_line, 1'b1);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wait_clks(Q);
      scl_release(); wait_clks(Q);
      sda_m = 1'b0; wait_clks(Q);
      scl_m = 1'b0; wait_clks(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wait_clks(Q);
      scl_release(); wait_clks(Q);
      sda_m = 1'b1; wait_clks(Q);
   endtask

   task automatic write_bit(input logic b);
      sda_m = b; wait_clks(Q);
      scl_release(); wait_clks(2 * Q);
      scl_m = 1'b0; wait_clks(Q);
   endtask

   task automatic read_bit(output logic b);
      sda_m = 1'b1; wait_clks(Q);
      scl_release(); wait_clks(Q);
      b = sda_line; wait_clks(Q);
      scl_m = 1'b0; wait_clks(Q);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(ack);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic nack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
      write_bit(nack);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sda_o"}, sda_o, 1'b1);
      check({tag, "_scl_o"}, scl_o, 1'b1);
      check({tag, "_rxdata"}, rxdata, 8'h00);
      check({tag, "_rw"}, rw, 1'b0);
      check({tag, "_addressed"}, addressed, 1'b0);
      check({tag, "_pulses"}, {rx_valid, tx_req, start_det, stop_det, ack_fail}, 5'b0);
   endtask

   // ------------------------------- sequence ---------------------------------
   initial begin
      logic       ack;
      logic       b;
      logic [7:0] d;
      int         c0, c1, c2, low_cnt;

      // Reset state
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;
      wait_clks(5);
      check("no_false_start", n_start, 0);

      // Write 0xA0, 0x3C
      c0 = n_start; c1 = n_rx; c2 = n_stop;
      i2c_start();
      write_byte(8'hA0, ack);
      check("wr_addr_ack", ack, 1'b0);
      check("wr_addressed", addressed, 1'b1);
      check("wr_rw", rw, 1'b0);
      exp_rx.push_back(8'h3C);
      write_byte(8'h3C, ack);
      check("wr_data_ack", ack, 1'b0);
      i2c_stop();
      wait_clks(5);
      check("wr_rx_count", n_rx - c1, 1);
      check("wr_rxdata", rxdata, 8'h3C);
      check("wr_start_count", n_start - c0, 1);
      check("wr_stop_count", n_stop - c2, 1);
      check("wr_addressed_after_stop", addressed, 1'b0);

      // Address mismatch 0xA2 plus one byte
      sda_low_seen = 1'b0;
      c1 = n_rx;
      i2c_start();
      write_byte(8'hA2, ack);
      check("mm_addr_nack", ack, 1'b1);
      check("mm_addressed", addressed, 1'b0);
      write_byte(8'h5A, ack);
      check("mm_data_nack", ack, 1'b1);
      check("mm_sda_never_low", sda_low_seen, 1'b0);
      check("mm_rx_count", n_rx - c1, 0);
      check("mm_rxdata_held", rxdata, 8'h3C);
      i2c_stop();

      // Read 0x96 twice, ACK then NACK
      tx_valid = 1'b1; txdata = 8'h96;
      c0 = n_txr; c1 = n_af;
      i2c_start();
      write_byte(8'hA1, ack);
      check("rd_addr_ack", ack, 1'b0);
      check("rd_addressed", addressed, 1'b1);
      check("rd_rw", rw, 1'b1);
      exp_tx.push_back(8'h96);
      read_byte(d, 1'b0);
      check("rd_byte0", d, exp_tx.pop_front());
      exp_tx.push_back(8'h96);
      read_byte(d, 1'b1);
      check("rd_byte1", d, exp_tx.pop_front());
      check("rd_tx_req_count", n_txr - c0, 2);
      check("rd_ack_fail_count", n_af - c1, 1);
      check("rd_wait_stop", dut.state_q, 4'd8);
      i2c_stop();
      check("rd_addressed_after_stop", addressed, 1'b0);

      // Clock stretch: tx_valid low for 50 cycles after address ACK
      tx_valid = 1'b0;
      c0 = n_txr;
      i2c_start();
      write_byte(8'hA1, ack);
      check("st_addr_ack", ack, 1'b0);
      low_cnt = 0;
      repeat (50) begin
         @(negedge clk);
         if (scl_o === 1'b0) low_cnt++;
      end
      check("st_scl_low_cycles", low_cnt, 50);
      check("st_no_tx_req", n_txr - c0, 0);
      txdata = 8'h5A;
      tx_valid = 1'b1;
      #1;
      check("st_scl_released", scl_o, 1'b1);
      exp_tx.push_back(8'h5A);
      read_byte(d, 1'b1);
      check("st_byte", d, exp_tx.pop_front());
      i2c_stop();

      // Repeated START after 4 write bits, then read address
      txdata = 8'h96;
      c1 = n_rx;
      i2c_start();
      write_byte(8'hA0, ack);
      check("rs_addr_ack", ack, 1'b0);
      write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
      c0 = n_start;
      i2c_start();
      check("rs_start_count", n_start - c0, 1);
      check("rs_addressed_cleared", addressed, 1'b0);
      write_byte(8'hA1, ack);
      check("rs_addr2_ack", ack, 1'b0);
      check("rs_rw", rw, 1'b1);
      check("rs_addressed", addressed, 1'b1);
      check("rs_no_rx_valid", n_rx - c1, 0);
      exp_tx.push_back(8'h96);
      read_byte(d, 1'b1);
      check("rs_byte", d, exp_tx.pop_front());
      i2c_stop();

      // Reset in the middle of a read byte
      i2c_start();
      write_byte(8'hA1, ack);
      check("rr_addr_ack", ack, 1'b0);
      d = 8'h00;
      for (int i = 7; i >= 4; i--) begin
         read_bit(b);
         d[i] = b;
      end
      check("rr_partial_bits", d[7:4], 4'h9);
      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs("midreset");
      reset = 1'b0;
      c0 = n_start;
      wait_clks(5);
      check("rr_no_false_start", n_start - c0, 0);
      i2c_start();
      write_byte(8'hA0, ack);
      check("rr_addr_ack_after_reset", ack, 1'b0);
      check("rr_addressed_after_reset", addressed, 1'b1);
      i2c_stop();
      wait_clks(5);
      check("rx_queue_drained", exp_rx.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/i2c_target_core.md
I2C_TARGET_CORE -- requirements
Module: i2c_target_core

Interface
REQ-001 Parameter TARGET_ADDR, default 7'h50: 7-bit target address this core answers to.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 sda_i  input  1  SDA line level, asynchronous to clk.
REQ-005 scl_i  input  1  SCL line level, asynchronous to clk.
REQ-006 sda_o  output  1  SDA drive; 0 = pull low, 1 = release.
REQ-007 scl_o  output  1  SCL drive for clock stretching; 0 = hold low, 1 = release.
REQ-008 rxdata  output  8  last byte written by the controller.
REQ-009 rx_valid  output  1  one-cycle pulse; rxdata updated this cycle.
REQ-010 txdata  input  8  next byte to return on a read.
REQ-011 tx_valid  input  1  txdata is ready to be consumed.
REQ-012 tx_req  output  1  one-cycle pulse; txdata consumed this cycle.
REQ-013 addressed  output  1  high while a transfer to TARGET_ADDR is active.
REQ-014 rw  output  1  R/W bit of the current transfer; 1 = read.
REQ-015 start_det, stop_det  output  1 each  one-cycle pulses on START (incl. repeated START) and STOP.
REQ-016 ack_fail  output  1  one-cycle pulse when the controller NACKs a read byte.

Function
REQ-017 sda_i and scl_i SHALL pass through 2-FF synchronizers plus one history register; all edge and condition detection SHALL use the synchronized values (3-cycle input latency).
REQ-018 START SHALL be detected as a falling synchronized SDA while synchronized SCL is high; STOP as a rising SDA while SCL is high.
REQ-019 FSM states SHALL be IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX_LOAD, TX, TX_ACK, WAIT_STOP.
REQ-020 START in any state SHALL pulse start_det, clear the bit counter, release sda_o and scl_o, deassert addressed, and enter ADDR.
REQ-021 STOP in any state SHALL pulse stop_det, release sda_o and scl_o, deassert addressed, and enter IDLE.
REQ-022 ADDR SHALL shift SDA in MSB first on each SCL rising edge; after the 8th bit it SHALL compare bits[7:1] with TARGET_ADDR.
REQ-023 On mismatch the core SHALL enter WAIT_STOP and drive nothing until the next START or STOP.
REQ-024 On match the core SHALL set addressed=1 and rw=bit[0], then drive sda_o=0 from the next SCL falling edge to the SCL falling edge after the 9th rising edge (ADDR_ACK).
REQ-025 Write path (rw=0): RX SHALL shift 8 bits on SCL rising edges; on the 8th, rxdata SHALL load and rx_valid SHALL pulse in that cycle; RX_ACK SHALL ACK as in REQ-024, then return to RX.
REQ-026 Read path (rw=1): at the SCL falling edge that ends ADDR_ACK or a master ACK, enter TX_LOAD.
REQ-027 In TX_LOAD, if tx_valid=1: load txdata, pulse tx_req, set sda_o=txdata[7], release scl_o, and enter TX in that cycle.
REQ-028 In TX_LOAD with tx_valid=0: hold scl_o=0 (stretch) until tx_valid=1, then proceed per REQ-027.
REQ-029 TX SHALL shift out one bit per SCL falling edge, MSB first; after the 8th falling edge sda_o SHALL be released and the core SHALL enter TX_ACK.
REQ-030 TX_ACK SHALL sample SDA on the 9th SCL rising edge: 0 = ACK, go to TX_LOAD on the next falling edge; 1 = NACK, pulse ack_fail and enter WAIT_STOP.
REQ-031 The bit counter SHALL be 4 bits, count 0..8, and clear on every byte boundary and START.
REQ-032 rxdata SHALL hold its value until the next completed write byte.
REQ-033 START and STOP SHALL override any byte in progress; partial bytes SHALL be discarded with no rx_valid or tx_req.

Reset
REQ-034 Reset SHALL force state=IDLE, sda_o=1, scl_o=1, rxdata=8'h00, rw=0, addressed=0, and all pulses=0, including mid-transfer and mid-stretch.
REQ-035 During the first 3 cycles after reset release, edges SHALL not be falsely detected; synchronizers SHALL reset to 1.

Verification
REQ-036 Write: START, 0xA0, 0x3C, STOP -> ACK on both 9th clocks, rx_valid once, rxdata=0x3C, stop_det pulse.
REQ-037 Mismatch: START, 0xA2, one byte -> sda_o stays 1 throughout, addressed=0, no rx_valid.
REQ-038 Read: START, 0xA1; tx_valid=1 with txdata=0x96; master ACKs, then NACKs the 2nd byte -> SDA bits 1,0,0,1,0,1,1,0; tx_req twice; ack_fail once; WAIT_STOP.
REQ-039 Stretch: read with tx_valid=0 for 50 cycles after address ACK -> scl_o=0 for those cycles, released the cycle tx_valid rises.
REQ-040 Repeated START mid-write after 4 bits, then 0xA1 -> no rx_valid, start_det pulse, rw=1, addressed=1.
REQ-041 Reset asserted mid-read-byte -> all outputs at REQ-034 values next cycle; a following START, 0xA0 is ACKed.
